// File: rtl/arm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : arm_mem_arbiter
// Brief    : Boot loader plus round-robin fetch/data arbiter for one
//            arm_memory port, with registered per-request responses.
// Revision : 1.0
// ============================================================================
module arm_mem_arbiter #(
    parameter logic [31:0] BOOT_BASE = 32'h0000_0000,
    parameter int          MEM_LAT   = 1,
    parameter bit          SKIP_BOOT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        boot_done,
    output logic        boot_err,
    input  logic        r0_req,
    input  logic [31:0] r0_addr,
    output logic        r0_gnt,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_excpt
);

    typedef enum logic [2:0] {
        S_BOOT_WAIT = 3'd0,
        S_BOOT_WR   = 3'd1,
        S_IDLE      = 3'd2,
        S_ACCESS    = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [1:0] c_LAT_LAST  = 2'(MEM_LAT - 1);
    localparam state_t     c_RST_STATE = SKIP_BOOT ? S_IDLE : S_BOOT_WAIT;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [31:0] r_ptr;
    logic        r_ld_last;
    logic        r_ld_ready;
    logic        r_boot_done;
    logic        r_boot_err;
    logic        r_last;
    logic        r_id;
    logic        r_we;
    logic        r_misalign;
    logic        r_r0_gnt;
    logic        r_r1_gnt;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;

    logic        w_lat_done;
    logic        w_accept;
    logic        w_any_req;
    logic        w_winner;
    logic [31:0] w_sel_addr;
    logic        w_sel_we;
    logic        w_misalign;

    assign w_lat_done = (r_cnt == c_LAT_LAST);
    assign w_accept   = (r_state == S_BOOT_WAIT) && ld_valid && r_ld_ready;
    assign w_any_req  = r0_req || r1_req;
    // On a tie the requester that was not granted last wins.
    assign w_winner   = r1_req && (!r0_req || !r_last);
    assign w_sel_addr = w_winner ? r1_addr : r0_addr;
    assign w_sel_we   = w_winner && r1_we;
    assign w_misalign = (w_sel_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT_WAIT: if (w_accept)   w_state_nxt = S_BOOT_WR;
            S_BOOT_WR:   if (w_lat_done) w_state_nxt = r_ld_last ? S_IDLE : S_BOOT_WAIT;
            S_IDLE:      if (w_any_req)  w_state_nxt = S_ACCESS;
            S_ACCESS:    if (r_misalign || w_lat_done) w_state_nxt = S_RESP;
            S_RESP:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = c_RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 2'd0;
            r_ptr       <= BOOT_BASE;
            r_ld_last   <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_boot_done <= SKIP_BOOT;
            r_boot_err  <= 1'b0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_misalign  <= 1'b0;
            r_r0_gnt    <= 1'b0;
            r_r1_gnt    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_r0_gnt    <= 1'b0;
            r_r1_gnt    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_ld_ready  <= (w_state_nxt == S_BOOT_WAIT);
            r_cnt       <= ((w_state_nxt == r_state) &&
                            (r_state == S_BOOT_WR || r_state == S_ACCESS)) ? r_cnt + 2'd1 : 2'd0;
            case (r_state)
                S_BOOT_WAIT: begin
                    if (w_accept) begin
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= ld_data;
                        r_mem_we    <= 1'b1;
                        r_ld_last   <= ld_last;
                    end
                end
                S_BOOT_WR: begin
                    if (w_lat_done) begin
                        r_boot_err <= r_boot_err | mem_excpt;
                        r_ptr      <= r_ptr + 32'd4;
                        if (r_ld_last) r_boot_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last     <= w_winner;
                        r_id       <= w_winner;
                        r_we       <= w_sel_we;
                        r_misalign <= w_misalign;
                        r_r0_gnt   <= !w_winner;
                        r_r1_gnt   <= w_winner;
                        // A misaligned request never reaches memory.
                        if (!w_misalign) begin
                            r_mem_addr <= w_sel_addr;
                            r_mem_we   <= w_sel_we;
                            if (w_sel_we) r_mem_wdata <= r1_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_misalign || w_lat_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_err   <= r_misalign | mem_excpt;
                        r_rsp_rdata <= (r_misalign || mem_excpt || r_we) ? 32'h0 : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ld_ready  = r_ld_ready;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;
    assign r0_gnt    = r_r0_gnt;
    assign r1_gnt    = r_r1_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: doc/arm_mem_arbiter.md
Name: arm_mem_arbiter

Overview:
Front-end controller for one port of arm_memory. It first runs a boot-load phase that streams words from a load interface into memory at consecutive word addresses. It then shares the same port between an instruction-fetch requester (r0, read-only) and a data requester (r1, read/write) using round-robin arbitration. It checks alignment, forwards memory exceptions as per-request errors, and returns registered responses.

Parameters:
BOOT_BASE, 32'h0000_0000, first word address written during boot load
MEM_LAT, 1, cycles from mem_addr/mem_we presentation to valid mem_rdata/mem_excpt (1..4)
SKIP_BOOT, 0, 1 = leave reset directly in IDLE with boot_done=1

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  boot word available
ld_data  in  32  boot word
ld_last  in  1  qualifies the final boot word
ld_ready  out  1  boot word accepted when ld_valid&&ld_ready
boot_done  out  1  high from boot completion until reset
boot_err  out  1  sticky: mem_excpt seen during a boot write
r0_req  in  1  fetch request, held until r0_gnt
r0_addr  in  32  fetch byte address
r0_gnt  out  1  one-cycle accept pulse
r1_req  in  1  data request, held until r1_gnt
r1_we  in  1  1 = write
r1_addr  in  32  data byte address
r1_wdata  in  32  write data
r1_gnt  out  1  one-cycle accept pulse
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  1  requester that owns the response (0/1)
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  misaligned address or mem_excpt
mem_addr  out  32  to arm_memory address
mem_wdata  out  32  to arm_memory data_in
mem_we  out  1  to arm_memory write enable
mem_rdata  in  32  from arm_memory data_out
mem_excpt  in  1  from arm_memory excpt

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, mem_we deasserted. State = BOOT, or IDLE with boot_done=1 if SKIP_BOOT. Load pointer = BOOT_BASE. RR pointer last=1, so r0 wins the first tie. Any in-flight access is abandoned with no response.
- States: BOOT_WAIT, BOOT_WR, IDLE, ACCESS, RESP.
- BOOT_WAIT: ld_ready=1. On ld_valid:
  - register mem_addr=pointer, mem_wdata=ld_data, mem_we=1 for exactly one cycle;
  - go to BOOT_WR and drop ld_ready.
- BOOT_WR: count MEM_LAT cycles.
  - On the last cycle, sample mem_excpt into boot_err (OR) and advance pointer +4. Pointer wraps at 32'hFFFF_FFFC to 0 silently.
  - If the accepted word had ld_last, go to IDLE and set boot_done; otherwise return to BOOT_WAIT.
- During BOOT states, r0_req/r1_req are ignored and no gnt is issued.
- IDLE, sampling at edge N:
  - Winner: the single requester; if both request, the one not last granted; the RR pointer is updated.
  - No requester: stay in IDLE.
- Cycle N+1 (ACCESS entry): winner's gnt high for one cycle.
  - Aligned (addr[1:0]==0): mem_addr=addr, mem_wdata=r1_wdata (r1 write), mem_we=1 only for an r1 write and only in this cycle.
  - Misaligned: no memory access (mem_we=0); jump to RESP with err.
- ACCESS: wait MEM_LAT cycles. Capture mem_rdata/mem_excpt on cycle N+MEM_LAT.
- RESP (cycle N+1+MEM_LAT): rsp_valid=1 for one cycle.
  - rsp_id = winner.
  - rsp_err = misaligned | captured excpt.
  - rsp_rdata = captured data for an error-free read, else 0.
  - Returns to IDLE; a new request sampled in this cycle is arbitrated.
- Throughput: one access per MEM_LAT+2 cycles. Only one outstanding access.
- A req dropped before gnt is treated as withdrawn, with no side effects. Address and data are sampled only at the IDLE decision edge.
- mem_addr/mem_wdata hold their last values when idle. mem_we is 0 outside issue cycles.

Test Plan:
- Boot load: 3 words 11111111, 22222222, 33333333 (last on the 3rd), BOOT_BASE=0 → mem writes at 0, 4, 8; one mem_we pulse each; ld_ready low during each write; boot_done rises after the 3rd; r0_req held throughout gets no gnt until boot_done.
- Read after boot: r0 reads addr 4, MEM_LAT=1 → r0_gnt at N+1, rsp_valid at N+2 with rsp_id=0, rsp_rdata=22222222, err=0.
- Contention: r0 and r1 request continuously from IDLE → grants alternate r0, r1, r0, r1; each response carries the correct id; one access per 3 cycles.
- Write then read: r1 writes DEADBEEF to 0x10, then reads 0x10 → write rsp_rdata=0, err=0; read returns DEADBEEF.
- Errors: r1 reads 0x13 → rsp_err=1, mem_we=0, no memory access; with mem_excpt forced during a boot write → boot_err=1 and stays 1 until reset.
- Mid-access reset: assert rst_n=0 during ACCESS on an r1 write → mem_we and all outputs go to 0 immediately; after release, state returns to BOOT_WAIT with ld_ready=1 and the pointer at BOOT_BASE.
